conv_mul_feeder: RTL and testbench

- Operand sequencer directly upstream of FP_MUL in the convolution datapath.
- Holds one KxK pixel window and one KxK weight kernel (IEEE-754 single) in local register arrays.
- On start, issues one (pixel, weight) pair per cycle to FP_MUL, then tracks FP_MUL's fixed pipeline latency.
- Re-emits each returned product tagged with its index and a last flag for the downstream accumulator.

---
 rtl/conv_pkg.sv | 8 +
 rtl/conv_tag_pipe.sv | 37 +++
 rtl/conv_mul_feeder.sv | 128 ++++++++++++
 tb/tb_conv_mul_feeder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared widths, FP zero mask, feeder state enum and default sizing for the conv datapath
package conv_pkg;
  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] FP_ZERO_MASK = 32'h7fff_ffff;
  localparam int DEF_K = 3;
  localparam int DEF_LAT = 5;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} feeder_state_t;
endpackage

// File: rtl/conv_tag_pipe.sv
// conv_tag_pipe: LAT-deep shift register of {valid, idx, last} tags with an any_valid flag
module conv_tag_pipe
  import conv_pkg::*;
#(
  parameter int LAT = DEF_LAT,
  parameter int IW = 4
) (
  input  logic          clock,
  input  logic          aclr,
  input  logic          in_valid,
  input  logic [IW-1:0] in_idx,
  input  logic          in_last,
  output logic          out_valid,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
  output logic          any_valid
);
  localparam int XW = LAT * IW;
  logic [LAT-1:0] v, l;
  logic [XW-1:0] ix;
  // shift one stage per cycle; the oldest tag falls off the top
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      v <= '0;
      l <= '0;
      ix <= '0;
    end else begin
      v <= LAT'({v, in_valid});
      l <= LAT'({l, in_last});
      ix <= XW'({ix, in_idx});
    end
  end
  assign out_valid = v[LAT-1];
  assign out_last = l[LAT-1];
  assign out_idx = ix[XW-1 -: IW];
  assign any_valid = |v;
endmodule

// File: rtl/conv_mul_feeder.sv
// conv_mul_feeder: issues KxK pixel/weight pairs to FP_MUL and re-emits tagged products; CONV_FEEDER_ZERO_SKIP_EN skips zero-weight pairs
module conv_mul_feeder
  import conv_pkg::*;
#(
  parameter int K = DEF_K,
  parameter int LAT = DEF_LAT,
  parameter int DW = FP_W,
  localparam int N = K * K,
  localparam int AW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clock,
  input  logic          aclr,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          wr_err,
  output logic [DW-1:0] mul_a,
  output logic [DW-1:0] mul_b,
  input  logic [DW-1:0] mul_result,
  output logic          prod_valid,
  output logic [DW-1:0] prod_data,
  output logic [AW-1:0] prod_idx,
  output logic          prod_last
);
  feeder_state_t state, nxt;
  logic [DW-1:0] pix [N];
  logic [DW-1:0] wgt [N];
  logic [AW-1:0] cnt, cnt_nxt, sel, t_idx, p_idx;
  logic [N-1:0] live;
  logic found, more, t_valid, t_last, p_valid, p_last, any_valid, wr_ok;
  assign wr_ok = wr_en && state == IDLE && int'(wr_addr) < N;
  assign busy = state == ISSUE || state == DRAIN;
  assign done = state == DONE;
  // pairs eligible for issue
  always_comb begin
    for (int i = 0; i < N; i++)
`ifdef CONV_FEEDER_ZERO_SKIP_EN
      live[i] = |(wgt[i] & FP_ZERO_MASK);
`else
      live[i] = 1'b1;
`endif
  end
  // lowest eligible index at or after cnt, and whether another one follows it
  always_comb begin
    sel = '0;
    found = 1'b0;
    more = 1'b0;
    for (int i = N - 1; i >= 0; i--)
      if (live[i] && i >= int'(cnt)) begin
        more = found;
        found = 1'b1;
        sel = AW'(i);
      end
  end
  // next state, operand drive and tag push
  always_comb begin
    nxt = state;
    cnt_nxt = cnt;
    t_valid = 1'b0;
    t_idx = sel;
    t_last = 1'b0;
    mul_a = '0;
    mul_b = '0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        nxt = start ? ISSUE : IDLE;
      end
      ISSUE: begin
        t_valid = found;
        t_last = found && !more;
        mul_a = found ? pix[sel] : '0;
        mul_b = found ? wgt[sel] : '0;
        cnt_nxt = sel + AW'(1);
        nxt = !found ? DONE : more ? ISSUE : DRAIN;
      end
      DRAIN: nxt = (!any_valid && prod_last) ? DONE : DRAIN;
      default: nxt = IDLE;
    endcase
  end
  // state, issue counter and sticky write error
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state <= IDLE;
      cnt <= '0;
      wr_err <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      if (state == IDLE && start) wr_err <= 1'b0;
      if (wr_en && !wr_ok) wr_err <= 1'b1;
    end
  end
  // operand storage, deliberately not reset
  always_ff @(posedge clock) begin
    if (wr_ok && wr_sel) wgt[wr_addr] <= wr_data;
    if (wr_ok && !wr_sel) pix[wr_addr] <= wr_data;
  end
  conv_tag_pipe #(.LAT(LAT), .IW(AW)) u_pipe (
    .clock(clock),
    .aclr(aclr),
    .in_valid(t_valid),
    .in_idx(t_idx),
    .in_last(t_last),
    .out_valid(p_valid),
    .out_idx(p_idx),
    .out_last(p_last),
    .any_valid(any_valid)
  );
  // register the product alongside its tag
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      prod_valid <= 1'b0;
      prod_data <= '0;
      prod_idx <= '0;
      prod_last <= 1'b0;
    end else begin
      prod_valid <= p_valid;
      prod_data <= mul_result;
      prod_idx <= p_idx;
      prod_last <= p_valid && p_last;
    end
  end
endmodule

// File: tb/tb_conv_mul_feeder.sv
// tb_conv_mul_feeder: directed bench for conv_mul_feeder with a pipelined FP_MUL model
module tb_conv_mul_feeder;
  localparam int LAT = 5;
  localparam int N = 9;
  logic clock = 1'b0, aclr = 1'b1, wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic busy, done, wr_err, prod_valid, prod_last;
  logic [31:0] mul_a, mul_b, mul_result, prod_data;
  logic [3:0] prod_idx;
  logic [31:0] mp [LAT];
  int total = 0, bad = 0, cyc = 0, done_cnt = 0, done_cyc = 0, c, d0;
  logic [31:0] q_data[$];
  int q_idx[$], q_cyc[$];
  logic q_last[$];
  logic [31:0] ed [N];
  int ei [N];
  logic [31:0] pix [N], wgt [N];

  conv_mul_feeder #(.K(3), .LAT(LAT), .DW(32)) dut (
    .clock(clock), .aclr(aclr), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(busy), .done(done), .wr_err(wr_err),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result), .prod_valid(prod_valid),
    .prod_data(prod_data), .prod_idx(prod_idx), .prod_last(prod_last)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    logic [47:0] m;
    int e;
    s = a[31] ^ b[31];
    if (a[30:0] == 0 || b[30:0] == 0) return {s, 31'b0};
    m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (m[47]) return {s, 8'(e + 1), m[46:24]};
    return {s, 8'(e), m[45:23]};
  endfunction

  always @(posedge clock or posedge aclr) begin
    if (aclr) begin
      for (int i = 0; i < LAT; i++) mp[i] <= '0;
    end else begin
      mp[0] <= fmul(mul_a, mul_b);
      for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
    end
  end
  assign mul_result = mp[LAT-1];

  always @(negedge clock) begin
    if (prod_valid) begin
      q_data.push_back(prod_data);
      q_idx.push_back(int'(prod_idx));
      q_last.push_back(prod_last);
      q_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic load(input logic sel, input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    wr_sel = sel;
    wr_addr = a;
    wr_data = d;
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < N; i++) begin
      load(1'b0, 4'(i), pix[i]);
      load(1'b1, 4'(i), wgt[i]);
    end
  endtask

  task automatic go(output int cs);
    q_data.delete();
    q_idx.delete();
    q_last.delete();
    q_cyc.delete();
    cs = cyc;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input logic hold);
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
    start = hold;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic check_window(input string tag, input int cs, input int n);
    chk({tag, "_count"}, 32'(q_idx.size()), 32'(n));
    for (int k = 0; k < n && k < q_idx.size(); k++) begin
      chk({tag, "_idx"}, 32'(q_idx[k]), 32'(ei[k]));
      chk({tag, "_data"}, q_data[k], ed[k]);
      chk({tag, "_last"}, 32'(q_last[k]), 32'(k == n - 1));
      chk({tag, "_cyc"}, 32'(q_cyc[k]), 32'(cs + 2 + k + LAT));
    end
    chk({tag, "_donecyc"}, 32'(done_cyc), 32'(n > 0 ? cs + 2 + n + LAT : cs + 2));
  endtask

  task automatic set_ident();
    ei = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
    ed = '{32'h42700000, 32'h40c00000, 0, 0, 0, 0, 0, 0, 32'h3fc00000};
  endtask

  initial begin
    pix = '{32'h41700000, 32'h40000000, 0, 0, 0, 0, 0, 0, 32'h40400000};
    wgt = '{32'h40800000, 32'h40400000, 0, 0, 0, 0, 0, 0, 32'h3f000000};
    repeat (2) @(negedge clock);
    chk("rst_ctl", 32'({busy, done, wr_err, prod_valid, prod_last}), 32'd0);
    chk("rst_mul_a", mul_a, 32'd0);
    chk("rst_mul_b", mul_b, 32'd0);
    chk("rst_prod", prod_data, 32'd0);
    chk("rst_idx", 32'(prod_idx), 32'd0);
    aclr = 1'b0;
    @(negedge clock);
    load_all();
    chk("load_err", 32'(wr_err), 32'd0);
    set_ident();
    // identity window
    go(c);
    chk("t0_busy", 32'(busy), 32'd1);
    chk("t0_mul_a", mul_a, 32'h41700000);
    chk("t0_mul_b", mul_b, 32'h40800000);
    @(negedge clock);
    chk("t1_mul_a", mul_a, 32'h40000000);
    chk("t1_mul_b", mul_b, 32'h40400000);
    repeat (8) @(negedge clock);
    chk("drain_mul", mul_a | mul_b, 32'd0);
    wait_done(1'b0);
    check_window("w1", c, N);
    chk("w1_busy", 32'(busy), 32'd0);
    chk("w1_dones", 32'(done_cnt), 32'd1);
    // write and start while busy
    d0 = done_cnt;
    go(c);
    load(1'b0, 4'd0, 32'h3f800000);
    chk("busy_wr_err", 32'(wr_err), 32'd1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(1'b0);
    check_window("w2", c, N);
    repeat (N + LAT + 4) @(negedge clock);
    chk("w2_dones", 32'(done_cnt), 32'(d0 + 1));
    chk("w2_err_sticky", 32'(wr_err), 32'd1);
    // accepted start clears the error
    go(c);
    chk("start_clr_err", 32'(wr_err), 32'd0);
    wait_done(1'b0);
    check_window("w3", c, N);
    load(1'b0, 4'd9, 32'h3f800000);
    chk("addr_err", 32'(wr_err), 32'd1);
    // start coincident with done is ignored, then back-to-back start
    go(c);
    wait_done(1'b1);
    check_window("w4", c, N);
    chk("done_start_ign", 32'(busy), 32'd0);
    go(c);
    wait_done(1'b0);
    check_window("w5", c, N);
    // reset mid-window
    d0 = done_cnt;
    go(c);
    for (int n = 0; !(prod_valid && prod_idx == 4'd4) && n < 100; n++) @(negedge clock);
    chk("rst_mid_reach", 32'(prod_idx), 32'd4);
    #2 aclr = 1'b1;
    #1;
    chk("rst_mid_ctl", 32'({busy, done, wr_err, prod_valid, prod_last}), 32'd0);
    chk("rst_mid_mul", mul_a | mul_b, 32'd0);
    chk("rst_mid_prod", prod_data | 32'(prod_idx), 32'd0);
    @(negedge clock);
    aclr = 1'b0;
    repeat (N + LAT + 4) @(negedge clock);
    chk("rst_mid_nodone", 32'(done_cnt), 32'(d0));
    chk("rst_mid_nprod", 32'(q_idx.size()), 32'd5);
    go(c);
    wait_done(1'b0);
    check_window("w6", c, N);
    // sparse weights
    wgt = '{0, 32'h40000000, 0, 0, 0, 0, 0, 32'h80000000, 32'h3f800000};
    load_all();
    go(c);
    wait_done(1'b0);
`ifdef CONV_FEEDER_ZERO_SKIP_EN
    ei[0] = 1; ei[1] = 8;
    ed[0] = 32'h40800000; ed[1] = 32'h40400000;
    check_window("zs", c, 2);
`else
    ei = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
    ed = '{0, 32'h40800000, 0, 0, 0, 0, 0, 32'h80000000, 32'h40400000};
    check_window("zs", c, N);
`endif
    // all-zero weights
    wgt = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    load_all();
    go(c);
    wait_done(1'b0);
`ifdef CONV_FEEDER_ZERO_SKIP_EN
    check_window("zall", c, 0);
`else
    ed = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    check_window("zall", c, N);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
